segment_scan_driver: RTL and testbench

Time-multiplexes four registered 7-segment patterns onto one shared segment bus plus four digit-select lines, for boards whose display digits share segment pins. Sits directly downstream of the segment generator: its Segment_0/Segment_1 outputs connect to Seg_0/Seg_1 here, with Seg_2/Seg_3 spare or driven by a second generator. Provides anti-ghosting blanking, per-digit enable and blink, and tear-free frame-boundary updates.

---
 rtl/segment_scan_driver_pkg.sv | 25 ++
 rtl/segment_scan_driver_if.sv | 26 ++
 rtl/segment_scan_driver_prescaler.sv | 31 +++
 rtl/segment_scan_driver.sv | 150 +++++++++++++++
 tb/tb_segment_scan_driver.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/segment_scan_driver_pkg.sv
// Shared constants, FSM state type and polarity helpers for the segment scan driver.
// Inactive levels are derived from the polarity parameters through the helper functions.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;
  localparam int DIG_W      = 2;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  function automatic logic [SEG_W-1:0] seg_inactive(input bit active_low);
    return active_low ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  endfunction

  function automatic logic [NUM_DIGITS-1:0] an_inactive(input bit active_low);
    return active_low ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  endfunction

  localparam logic [SEG_W-1:0]      SEG_OFF_DEFAULT = seg_inactive(1'b1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF_DEFAULT  = an_inactive(1'b1);

endpackage

// File: rtl/segment_scan_driver_if.sv
// Pattern/enable inputs and scanned display outputs of the segment scan driver.
// master = pattern source / board side, slave = the driver itself.
interface segment_scan_driver_if;
  import seg_scan_pkg::*;

  logic [SEG_W-1:0]      Seg_0;
  logic [SEG_W-1:0]      Seg_1;
  logic [SEG_W-1:0]      Seg_2;
  logic [SEG_W-1:0]      Seg_3;
  logic [NUM_DIGITS-1:0] Digit_En;
  logic [NUM_DIGITS-1:0] Blink_En;
  logic [SEG_W-1:0]      Seg_Out;
  logic [NUM_DIGITS-1:0] An_Out;
  logic                  Frame_Done;

  modport master (
    output Seg_0, Seg_1, Seg_2, Seg_3, Digit_En, Blink_En,
    input  Seg_Out, An_Out, Frame_Done
  );

  modport slave (
    input  Seg_0, Seg_1, Seg_2, Seg_3, Digit_En, Blink_En,
    output Seg_Out, An_Out, Frame_Done
  );

endinterface

// File: rtl/segment_scan_driver_prescaler.sv
// Slot counter: counts 0..DIV_TERM-1 and flags the last count of each slot.
// wrap_o is combinational from the count register, so it is high during cnt = DIV_TERM-1.
module seg_prescaler #(
  parameter int DIV_TERM = 50000,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign wrap_o = (cnt_q == CNT_W'(DIV_TERM - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/segment_scan_driver.sv
// Multiplexes four shadowed 7-segment patterns onto a shared bus with anti-ghost blanking and blink.
// All outputs registered one clock behind the slot state; shadows reload only at the frame wrap.
module segment_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int DIV_TERM       = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int BLINK_FRAMES   = 128,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input logic                  CLK,
  input logic                  Reset,
  segment_scan_driver_if.slave bus
);

  localparam int CNT_W      = $clog2(DIV_TERM);
  localparam int FC_W       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam logic [SEG_W-1:0]      SEG_OFF = seg_inactive(SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = an_inactive(AN_ACTIVE_LOW != 0);
  localparam state_t STATE_RST = (BLANK_CYCLES > 0) ? S_BLANK : S_SHOW;

  if (DIV_TERM < 2) begin : g_bad_div
    $error("DIV_TERM must be at least 2");
  end
  if (BLANK_CYCLES >= DIV_TERM) begin : g_bad_blank
    $error("BLANK_CYCLES must be less than DIV_TERM");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("BLINK_FRAMES must be at least 1");
  end

  logic [CNT_W-1:0] cnt;
  logic             slot_wrap;
  logic             frame_wrap;

  state_t                state_q, state_d;
  logic [DIG_W-1:0]      dig_q, dig_d;
  logic [FC_W-1:0]       fcnt_q, fcnt_d;
  logic                  blink_q, blink_d;
  logic [SEG_W-1:0]      seg_sh_q [NUM_DIGITS];
  logic [SEG_W-1:0]      seg_sh_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] den_sh_q, den_sh_d;
  logic [NUM_DIGITS-1:0] ben_sh_q, ben_sh_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q, fd_d;

  logic [SEG_W-1:0]      pattern;
  logic [NUM_DIGITS-1:0] sel;
  logic                  lit;

  seg_prescaler #(
    .DIV_TERM (DIV_TERM),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk    (CLK),
    .rst_n  (Reset),
    .cnt_o  (cnt),
    .wrap_o (slot_wrap)
  );

  assign frame_wrap = slot_wrap && (dig_q == DIG_W'(NUM_DIGITS - 1));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= STATE_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // BLANK covers counts 0..BLANK_CYCLES-1 of every slot; with zero blank cycles the FSM stays in SHOW.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BLANK: if (cnt == CNT_W'(BLANK_LAST)) state_d = S_SHOW;
      S_SHOW:  if (slot_wrap && (BLANK_CYCLES > 0)) state_d = S_BLANK;
      default: state_d = STATE_RST;
    endcase
  end

  always_comb begin
    pattern = seg_sh_q[dig_q];
    sel     = '0;
    sel[dig_q] = 1'b1;
    lit     = (state_q == S_SHOW) && den_sh_q[dig_q] && !(blink_q && ben_sh_q[dig_q]);
    seg_d   = SEG_OFF;
    an_d    = AN_OFF;
    if (lit) begin
      seg_d = (SEG_ACTIVE_LOW != 0) ? ~pattern : pattern;
      an_d  = (AN_ACTIVE_LOW != 0) ? ~sel : sel;
    end
    fd_d = frame_wrap;
  end

  always_comb begin
    dig_d    = slot_wrap ? dig_q + 1'b1 : dig_q;
    fcnt_d   = fcnt_q;
    blink_d  = blink_q;
    seg_sh_d = seg_sh_q;
    den_sh_d = den_sh_q;
    ben_sh_d = ben_sh_q;
    if (frame_wrap) begin
      if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
      seg_sh_d[0] = bus.Seg_0;
      seg_sh_d[1] = bus.Seg_1;
      seg_sh_d[2] = bus.Seg_2;
      seg_sh_d[3] = bus.Seg_3;
      den_sh_d    = bus.Digit_En;
      ben_sh_d    = bus.Blink_En;
    end
  end

  // Output registers reset to the inactive levels so the display goes dark as soon as Reset falls.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      dig_q    <= '0;
      fcnt_q   <= '0;
      blink_q  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) seg_sh_q[i] <= '0;
      den_sh_q <= '0;
      ben_sh_q <= '0;
      seg_q    <= SEG_OFF;
      an_q     <= AN_OFF;
      fd_q     <= 1'b0;
    end else begin
      dig_q    <= dig_d;
      fcnt_q   <= fcnt_d;
      blink_q  <= blink_d;
      seg_sh_q <= seg_sh_d;
      den_sh_q <= den_sh_d;
      ben_sh_q <= ben_sh_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
    end
  end

  assign bus.Seg_Out    = seg_q;
  assign bus.An_Out     = an_q;
  assign bus.Frame_Done = fd_q;

endmodule

// File: tb/tb_segment_scan_driver.sv
// Bench for segment_scan_driver: per-cycle scoreboard against a position-based model,
// a table of frame configurations, and hand sequences for reset, tearing, blink and boundary.
module tb_segment_scan_driver;
  import seg_scan_pkg::*;

  localparam int DT    = 8;
  localparam int BC    = 2;
  localparam int BF    = 2;
  localparam int FRAME = NUM_DIGITS * DT;

  typedef struct {
    logic [SEG_W-1:0]      seg;
    logic [NUM_DIGITS-1:0] an;
    logic                  fd;
  } obs_t;

  typedef struct {
    logic [3:0][6:0] seg_i;
    logic [3:0]      den;
    logic [3:0][6:0] exp_seg;
    logic [3:0][3:0] exp_an;
    int              exp_lit;
  } vec_t;

  logic CLK   = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  logic [3:0][6:0] seg_in = '0;
  logic [3:0]      den_in = '0;
  logic [3:0]      ben_in = '0;

  segment_scan_driver_if bus();
  assign bus.Seg_0    = seg_in[0];
  assign bus.Seg_1    = seg_in[1];
  assign bus.Seg_2    = seg_in[2];
  assign bus.Seg_3    = seg_in[3];
  assign bus.Digit_En = den_in;
  assign bus.Blink_En = ben_in;

  segment_scan_driver #(
    .DIV_TERM       (DT),
    .BLANK_CYCLES   (BC),
    .BLINK_FRAMES   (BF),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  int              n_checks = 0;
  int              n_errors = 0;
  int              m = 0;
  logic [3:0][6:0] msh = '0;
  logic [3:0]      mden = '0;
  logic [3:0]      mben = '0;
  obs_t            sb_q[$];
  obs_t            last;

  logic [3:0][6:0] cap_lit_seg, cap_blank_seg;
  logic [3:0][3:0] cap_lit_an, cap_blank_an;
  int              cap_fd_first, cap_fd_cnt, cap_lit_cycles;
  int              chg_at = -1;
  logic [6:0]      chg_val = '0;
  vec_t            vecs[3];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected registered outputs after the next edge, from the model position m since reset release.
  function automatic obs_t model_out();
    obs_t o;
    int   cnt, dig, w;
    logic ph, lt;
    cnt  = m % DT;
    dig  = (m / DT) % NUM_DIGITS;
    w    = m / FRAME;
    ph   = ((w / BF) % 2) == 1;
    lt   = (cnt >= BC) && mden[dig] && !(ph && mben[dig]);
    o.seg = lt ? ~msh[dig] : 7'h7F;
    o.an  = lt ? ~(4'b0001 << dig) : 4'hF;
    o.fd  = (m % FRAME) == FRAME - 1;
    return o;
  endfunction

  task automatic step();
    obs_t e;
    obs_t g;
    sb_q.push_back(model_out());
    @(posedge CLK);
    if ((m % FRAME) == FRAME - 1) begin
      msh  = seg_in;
      mden = den_in;
      mben = ben_in;
    end
    m++;
    #1;
    g.seg = bus.Seg_Out;
    g.an  = bus.An_Out;
    g.fd  = bus.Frame_Done;
    last  = g;
    e = sb_q.pop_front();
    chk("scoreboard", {20'd0, g.seg, g.an, g.fd}, {20'd0, e.seg, e.an, e.fd});
  endtask

  task automatic wait_fd(input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cycles && !seen; k++) begin
      step();
      if (last.fd) seen = 1'b1;
    end
    chk("wait_fd_timeout", 32'(seen), 32'd1);
  endtask

  task automatic capture_frame();
    cap_fd_cnt     = 0;
    cap_fd_first   = -1;
    cap_lit_cycles = 0;
    for (int j = 1; j <= FRAME; j++) begin
      if (j == chg_at) seg_in[1] = chg_val;
      step();
      if (last.fd) begin
        cap_fd_cnt++;
        if (cap_fd_first < 0) cap_fd_first = j;
      end
      if (last.an != 4'hF) cap_lit_cycles++;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (j == DT * d + 1) begin
          cap_blank_seg[d] = last.seg;
          cap_blank_an[d]  = last.an;
        end
        if (j == DT * d + 6) begin
          cap_lit_seg[d] = last.seg;
          cap_lit_an[d]  = last.an;
        end
      end
    end
    chg_at = -1;
  endtask

  // Assert Reset between edges, check outputs go inactive with no clock edge, release on a negedge.
  task automatic async_reset(input string tag);
    #2 Reset = 1'b0;
    #1;
    chk({tag, "_seg_now"}, 32'(bus.Seg_Out), 32'h7F);
    chk({tag, "_an_now"}, 32'(bus.An_Out), 32'hF);
    chk({tag, "_fd_now"}, 32'(bus.Frame_Done), 32'h0);
    repeat (2) @(negedge CLK);
    chk({tag, "_an_held"}, 32'(bus.An_Out), 32'hF);
    Reset = 1'b1;
    m    = 0;
    msh  = '0;
    mden = '0;
    mben = '0;
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit0[4];
    int cnt0, cnt1;
    bit reached;

    vecs[0].seg_i   = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    vecs[0].den     = 4'hF;
    vecs[0].exp_seg = {7'h30, 7'h24, 7'h79, 7'h40};
    vecs[0].exp_an  = {4'h7, 4'hB, 4'hD, 4'hE};
    vecs[0].exp_lit = 24;
    vecs[1].seg_i   = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    vecs[1].den     = 4'b0011;
    vecs[1].exp_seg = {7'h7F, 7'h7F, 7'h79, 7'h40};
    vecs[1].exp_an  = {4'hF, 4'hF, 4'hD, 4'hE};
    vecs[1].exp_lit = 12;
    vecs[2].seg_i   = {7'h40, 7'h01, 7'h7F, 7'h00};
    vecs[2].den     = 4'hF;
    vecs[2].exp_seg = {7'h3F, 7'h7E, 7'h00, 7'h7F};
    vecs[2].exp_an  = {4'h7, 4'hB, 4'hD, 4'hE};
    vecs[2].exp_lit = 24;

    async_reset("init");

    // Inputs presented now are only captured at the end of the first frame, which stays dark.
    seg_in = vecs[0].seg_i;
    den_in = 4'hF;
    capture_frame();
    chk("first_frame_dark", 32'(cap_lit_cycles), 32'd0);
    chk("first_fd_pos", 32'(cap_fd_first), 32'(FRAME));

    for (int i = 0; i < 3; i++) begin
      seg_in = vecs[i].seg_i;
      den_in = vecs[i].den;
      ben_in = '0;
      wait_fd(2 * FRAME);
      capture_frame();
      for (int d = 0; d < NUM_DIGITS; d++) begin
        chk($sformatf("v%0d_d%0d_seg", i, d), 32'(cap_lit_seg[d]), 32'(vecs[i].exp_seg[d]));
        chk($sformatf("v%0d_d%0d_an", i, d), 32'(cap_lit_an[d]), 32'(vecs[i].exp_an[d]));
        chk($sformatf("v%0d_d%0d_blank", i, d), {21'd0, cap_blank_seg[d], cap_blank_an[d]}, {21'd0, 7'h7F, 4'hF});
      end
      chk($sformatf("v%0d_fd_pos", i), 32'(cap_fd_first), 32'(FRAME));
      chk($sformatf("v%0d_fd_cnt", i), 32'(cap_fd_cnt), 32'd1);
      chk($sformatf("v%0d_lit_cycles", i), 32'(cap_lit_cycles), 32'(vecs[i].exp_lit));
    end

    // Seg_1 changes early in the frame, before digit 1's slot; the old pattern must persist.
    seg_in = vecs[0].seg_i;
    den_in = 4'hF;
    wait_fd(2 * FRAME);
    chg_at  = 3;
    chg_val = 7'h7F;
    capture_frame();
    chk("tear_same_frame", 32'(cap_lit_seg[1]), 32'h79);
    capture_frame();
    chk("tear_next_frame", 32'(cap_lit_seg[1]), 32'h00);
    chk("tear_next_an", 32'(cap_lit_an[1]), 32'hD);

    seg_in = vecs[0].seg_i;
    ben_in = 4'b0001;
    wait_fd(2 * FRAME);
    cnt0 = 0;
    cnt1 = 0;
    for (int f = 0; f < 4; f++) begin
      capture_frame();
      lit0[f] = (cap_lit_an[0] == 4'hE) ? 1 : 0;
      cnt0 += lit0[f];
      if (cap_lit_an[1] == 4'hD && cap_lit_seg[1] == 7'h79) cnt1++;
    end
    chk("blink_d0_lit_frames", 32'(cnt0), 32'd2);
    chk("blink_d0_pairs_a", 32'(lit0[0] != lit0[2]), 32'd1);
    chk("blink_d0_pairs_b", 32'(lit0[1] != lit0[3]), 32'd1);
    chk("blink_d1_steady", 32'(cnt1), 32'd4);

    // Seg_0 set just before the loading edge, then changed again in the Frame_Done cycle.
    ben_in  = '0;
    reached = 1'b0;
    for (int k = 0; k < 2 * FRAME && !reached; k++) begin
      if ((m % FRAME) == FRAME - 1) reached = 1'b1;
      else step();
    end
    chk("boundary_reach", 32'(reached), 32'd1);
    seg_in[0] = 7'h77;
    step();
    chk("boundary_fd", 32'(last.fd), 32'd1);
    seg_in[0] = 7'h3F;
    capture_frame();
    chk("boundary_capture", 32'(cap_lit_seg[0]), 32'h08);
    capture_frame();
    chk("boundary_next", 32'(cap_lit_seg[0]), 32'h40);

    reached = 1'b0;
    for (int k = 0; k < 2 * FRAME && !reached; k++) begin
      step();
      if ((m % FRAME) == 3 * DT + 5) reached = 1'b1;
    end
    chk("dig3_reach", 32'(reached), 32'd1);
    chk("pre_reset_lit", 32'(last.an), 32'h7);
    async_reset("dig3");
    capture_frame();
    chk("post_reset_dark", 32'(cap_lit_cycles), 32'd0);
    chk("post_reset_fd_pos", 32'(cap_fd_first), 32'(FRAME));
    capture_frame();
    chk("post_reset_order", 32'(cap_lit_an), 32'h7BDE);
    chk("post_reset_seg0", 32'(cap_lit_seg[0]), 32'h40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
